// File: rtl/bram_rd_port_arbiter.sv
// Round-robin arbiter sharing one BRAM read port among NUM_REQ requesters,
// with per-requester burst lock and read-data return tagged to the issuer.
//
// Ports: clk, rst_n (async, active-low), clear (sync flush),
//   req/lock/addr per requester, gnt (registered one-hot),
//   rd_valid/rd_data return path, bram_rd_en/addr/data BRAM side, busy.
module bram_rd_port_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          bram_rd_en,
  output logic [ADDR_WIDTH-1:0]         bram_rd_addr,
  input  logic [DATA_WIDTH-1:0]         bram_rd_data,
  output logic                          busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t                               state;
  logic [IW-1:0]                        rr_ptr;
  logic [IW-1:0]                        gidx;
  logic [IW-1:0]                        ptr_nxt;
  logic [NUM_REQ-1:0]                   xfer_vec;
  logic [NUM_REQ-1:0]                   arb_gnt;
  logic                                 xfer;
  logic                                 lock_sel;
  logic [RD_LATENCY-1:0][NUM_REQ-1:0]   tag_q;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gidx = IW'(i);
    end
  end

  assign xfer_vec = gnt & req;
  assign xfer     = |xfer_vec;
  assign lock_sel = |(gnt & lock);

  // Pointer used for the next arbitration: advances past the
  // requester that transferred this cycle so grants rotate
  // without a bubble.
  assign ptr_nxt = !xfer ? rr_ptr :
                   (gidx == IW'(NUM_REQ - 1)) ? '0 :
                   gidx + IW'(1);

  always_comb begin
    int  idx;
    logic hit;
    idx     = 0;
    hit     = 1'b0;
    arb_gnt = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_nxt) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!hit && req[idx]) begin
        arb_gnt[idx] = 1'b1;
        hit          = 1'b1;
      end
    end
  end

  always_comb begin
    bram_rd_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (xfer_vec[i])
        bram_rd_addr = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  assign bram_rd_en = xfer;
  assign rd_data    = bram_rd_data;
  assign rd_valid   = tag_q[RD_LATENCY-1];
  assign busy       = (|gnt) | (|tag_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt    <= '0;
      rr_ptr <= '0;
      tag_q  <= '0;
    end else if (clear) begin
      // Flush wins over a same-cycle transfer; rr_ptr is kept.
      state <= IDLE;
      gnt   <= '0;
      tag_q <= '0;
    end else begin
      tag_q[0] <= xfer_vec;
      for (int k = 1; k < RD_LATENCY; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
      if (xfer) rr_ptr <= ptr_nxt;
      unique case (state)
        IDLE: begin
          if (xfer && lock_sel) state <= LOCKED;
          else                  gnt   <= arb_gnt;
        end
        LOCKED: begin
          if (!(xfer && lock_sel)) begin
            state <= IDLE;
            gnt   <= arb_gnt;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_rd_port_arbiter.sv
// Testbench for bram_rd_port_arbiter: two instances (read latency 1 and 2)
// share stimulus and are checked each cycle against a behavioural model.
module tb_bram_rd_port_arbiter;

  localparam int NR = 3;
  localparam int AW = 14;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            clear;
  logic [NR-1:0]   req;
  logic [NR-1:0]   lock;
  logic [NR*AW-1:0] addr_bus;

  logic [NR-1:0]   gnt1, gnt2, vld1, vld2;
  logic [DW-1:0]   data1, data2, bd1, bd2, p2;
  logic            en1, en2, busy1, busy2;
  logic [AW-1:0]   baddr1, baddr2;

  int n_vec = 0;
  int n_err = 0;

  int           m_gnt;
  int           m_ptr;
  int           h_req [1:2];
  logic [AW-1:0] h_addr [1:2];

  always #5 clk = ~clk;

  bram_rd_port_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)
  ) u_l1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .req(req), .lock(lock),
    .addr(addr_bus), .gnt(gnt1), .rd_valid(vld1), .rd_data(data1),
    .bram_rd_en(en1), .bram_rd_addr(baddr1), .bram_rd_data(bd1),
    .busy(busy1)
  );

  bram_rd_port_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2)
  ) u_l2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .req(req), .lock(lock),
    .addr(addr_bus), .gnt(gnt2), .rd_valid(vld2), .rd_data(data2),
    .bram_rd_en(en2), .bram_rd_addr(baddr2), .bram_rd_data(bd2),
    .busy(busy2)
  );

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return 32'hA5C3_0000 ^ ({18'd0, a} * 32'h0000_9E37);
  endfunction

  // Synchronous BRAM models, one and two cycles deep.
  always @(posedge clk) begin
    if (en1) bd1 <= mem(baddr1);
    if (en2) p2 <= mem(baddr2);
    bd2 <= p2;
  end

  function automatic logic [NR-1:0] oh(input int i);
    logic [NR-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int i);
    return addr_bus[i*AW +: AW];
  endfunction

  function automatic int pick(input int ptr);
    for (int k = 0; k < NR; k++) begin
      if (req[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_gnt     = -1;
    m_ptr     = 0;
    h_req[1]  = -1;
    h_req[2]  = -1;
    h_addr[1] = '0;
    h_addr[2] = '0;
  endtask

  task automatic step();
    int x;
    #1;
    x = -1;
    if (m_gnt >= 0) begin
      if (req[m_gnt]) x = m_gnt;
    end
    chk("gnt_l1", 64'(gnt1), 64'(oh(m_gnt)));
    chk("gnt_l2", 64'(gnt2), 64'(oh(m_gnt)));
    chk("en_l1", 64'(en1), 64'(x >= 0));
    chk("en_l2", 64'(en2), 64'(x >= 0));
    chk("addr_l1", 64'(baddr1), (x >= 0) ? 64'(addr_of(x)) : 64'd0);
    chk("addr_l2", 64'(baddr2), (x >= 0) ? 64'(addr_of(x)) : 64'd0);
    chk("vld_l1", 64'(vld1), 64'(oh(h_req[1])));
    chk("vld_l2", 64'(vld2), 64'(oh(h_req[2])));
    if (h_req[1] >= 0) chk("data_l1", 64'(data1), 64'(mem(h_addr[1])));
    if (h_req[2] >= 0) chk("data_l2", 64'(data2), 64'(mem(h_addr[2])));
    chk("busy_l1", 64'(busy1), 64'(m_gnt >= 0 || h_req[1] >= 0));
    chk("busy_l2", 64'(busy2),
        64'(m_gnt >= 0 || h_req[1] >= 0 || h_req[2] >= 0));
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      h_req[2]  = h_req[1];
      h_addr[2] = h_addr[1];
      h_req[1]  = x;
      h_addr[1] = (x >= 0) ? addr_of(x) : '0;
      if (clear) begin
        h_req[1] = -1;
        h_req[2] = -1;
        m_gnt    = -1;
      end else begin
        if (x >= 0) m_ptr = (x + 1) % NR;
        if (x >= 0 && lock[x]) m_gnt = x;
        else                   m_gnt = pick(m_ptr);
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_addr();
    for (int i = 0; i < NR; i++) begin
      addr_bus[i*AW +: AW] = AW'($urandom);
    end
  endtask

  // Asynchronous reset in the middle of the low clock phase.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt_l1", 64'(gnt1), 64'd0);
    chk("arst_gnt_l2", 64'(gnt2), 64'd0);
    chk("arst_vld_l1", 64'(vld1), 64'd0);
    chk("arst_vld_l2", 64'(vld2), 64'd0);
    chk("arst_en_l1", 64'(en1), 64'd0);
    chk("arst_en_l2", 64'(en2), 64'd0);
    model_reset();
  endtask

  initial begin
    rst_n    = 1'b0;
    clear    = 1'b0;
    req      = '0;
    lock     = '0;
    addr_bus = '0;
    model_reset();
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;

    // Lone requester 0 at 0x0010.
    addr_bus[0 +: AW] = 14'h0010;
    req = 3'b001;
    step();
    step();
    req = 3'b000;
    step();
    step();
    step();

    // All three requesting, pointer back at 0.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req = 3'b111;
    for (int c = 0; c < 8; c++) begin
      rand_addr();
      step();
    end
    req = 3'b000;
    step();
    step();

    // Requester 1 bursts under lock while 0 and 2 wait.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req  = 3'b010;
    lock = 3'b010;
    step();
    req = 3'b111;
    for (int c = 0; c < 3; c++) begin
      rand_addr();
      step();
    end
    lock = 3'b000;
    for (int c = 0; c < 5; c++) begin
      rand_addr();
      step();
    end
    req = 3'b000;
    step();
    step();

    // Requester 2 withdraws as its grant rises.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req = 3'b100;
    step();
    req = 3'b011;
    step();
    step();
    step();
    req = 3'b000;
    step();
    step();
    step();

    // Clear one cycle after a transfer.
    req = 3'b001;
    addr_bus[0 +: AW] = 14'h0123;
    step();
    step();
    req   = 3'b000;
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    step();
    step();

    // Async reset during a locked burst, then restart.
    req  = 3'b111;
    lock = 3'b010;
    for (int c = 0; c < 4; c++) begin
      rand_addr();
      step();
    end
    async_reset();
    step();
    rst_n = 1'b1;
    lock  = 3'b000;
    for (int c = 0; c < 5; c++) begin
      rand_addr();
      step();
    end

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      req   = NR'($urandom);
      lock  = NR'($urandom) & NR'($urandom);
      clear = ($urandom_range(0, 15) == 0);
      rand_addr();
      step();
    end
    clear = 1'b0;
    req   = '0;
    lock  = '0;
    step();
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
